control_unit: RTL and testbench

- Multi-cycle control FSM for the RV32I core.
- Sequences instruction fetch, decode, execute, memory access and writeback around the combinational instruction decoder, ALU, register file and single-port memory bus.
- Consumes decoder fields (opcode, func3, instr_valid) and drives every datapath select/enable, the memory request handshake, a retire counter and a halt/cause status.

---
 rtl/control_unit_pkg.sv | 89 ++++++++
 rtl/control_unit_timeout_counter.sv | 44 ++++
 rtl/control_unit.sv | 219 +++++++++++++++++++++
 tb/tb_control_unit.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// -----------------------------------------------------------------------------
// control_unit_pkg
//   Shared encodings for the RV32I multi-cycle control unit: FSM state codes,
//   datapath select codes, halt cause codes and the RV32I major opcodes.
//   Also provides the opcode -> ALU operand select mapping, which is used in
//   every cycle where the ALU result is consumed (EXECUTE, MEM, WRITEBACK).
// -----------------------------------------------------------------------------
package control_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEM       = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_HALT      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    PC_SRC_PLUS4 = 2'd0,
    PC_SRC_IMM   = 2'd1,
    PC_SRC_ALU   = 2'd2
  } pc_src_e;

  typedef enum logic [1:0] {
    ALU_A_RS1  = 2'd0,
    ALU_A_PC   = 2'd1,
    ALU_A_ZERO = 2'd2
  } alu_a_e;

  typedef enum logic {
    ALU_B_RS2 = 1'b0,
    ALU_B_IMM = 1'b1
  } alu_b_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ECALL   = 2'd1,
    CAUSE_ILLEGAL = 2'd2,
    CAUSE_TIMEOUT = 2'd3
  } cause_e;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MEM_MISC = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    alu_a_e a_sel;
    alu_b_e b_sel;
  } alu_sel_t;

  // ALU operand selects for an opcode. JAL, BRANCH, OP and anything
  // unlisted use rs1/rs2 (JAL ignores the ALU entirely).
  function automatic alu_sel_t alu_sel_for(input logic [6:0] opc);
    alu_sel_t s;
    s.a_sel = ALU_A_RS1;
    s.b_sel = ALU_B_RS2;
    case (opc)
      OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_JALR: s.b_sel = ALU_B_IMM;
      OPC_LUI: begin
        s.a_sel = ALU_A_ZERO;
        s.b_sel = ALU_B_IMM;
      end
      OPC_AUIPC: begin
        s.a_sel = ALU_A_PC;
        s.b_sel = ALU_B_IMM;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/control_unit_timeout_counter.sv
// -----------------------------------------------------------------------------
// ctrl_timeout_counter
//   Memory-bus watchdog. Counts cycles in which a request is pending without
//   completion; 'expired' is asserted in the cycle that would bring the count
//   to MEM_TIMEOUT, so the FSM leaves the bus after exactly MEM_TIMEOUT
//   waiting cycles. MEM_TIMEOUT = 0 disables the watchdog.
// Ports:
//   clk, reset_n  clock / asynchronous active-low reset
//   en            a request is waiting this cycle
//   clr           request idle or completing; clears the count (wins over en)
//   expired       waiting limit reached this cycle
// -----------------------------------------------------------------------------
module ctrl_timeout_counter #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

  logic [CW-1:0] count_q;
  logic          counting;

  assign counting = en && !clr;
  assign expired  = (MEM_TIMEOUT > 0) && counting && (count_q == LAST);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (!counting) begin
      count_q <= '0;
    end else if ((MEM_TIMEOUT > 0) && (count_q != LAST)) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Multi-cycle RV32I control FSM: IDLE -> FETCH -> DECODE -> EXECUTE
//   [-> MEM] [-> WRITEBACK] -> FETCH, with HALT as an absorbing state for
//   ECALL/EBREAK, illegal instructions and memory-bus timeouts.
// Ports:
//   clk, reset_n          clock / asynchronous active-low reset
//   opcode, func3         decoder fields from the IR (stable after FETCH)
//   instr_valid           decoder legality flag
//   branch_taken          ALU compare result for the current branch
//   mem_ready             memory completes the pending request this cycle
//   mem_req/mem_we        memory request handshake, 1 = store
//   mem_addr_sel          memory address: 0 = PC, 1 = ALU result
//   ir_load, pc_write     IR and PC load enables
//   pc_src                0 = PC+4, 1 = PC+imm, 2 = ALU result
//   alu_a_sel/alu_b_sel   ALU operand selects
//   reg_write, wb_sel     register write enable / writeback source
//   retire, instret       per-instruction pulse and wrapping count
//   halted, cause, state  status and debug view
// -----------------------------------------------------------------------------
module control_unit
  import control_unit_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           func3,
  input  logic                 instr_valid,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 mem_addr_sel,
  output logic                 ir_load,
  output logic                 pc_write,
  output logic [1:0]           pc_src,
  output logic [1:0]           alu_a_sel,
  output logic                 alu_b_sel,
  output logic                 reg_write,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] instret,
  output logic                 halted,
  output logic [1:0]           cause,
  output logic [2:0]           state
);

  state_e   state_q, state_d;
  cause_e   cause_q, cause_d;
  logic     timeout_expired;
  alu_sel_t alu_sel;
  logic [CNT_WIDTH-1:0] instret_q;

  assign alu_sel = alu_sel_for(opcode);

  ctrl_timeout_counter #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (mem_req && !mem_ready),
    .clr     (!mem_req || mem_ready),
    .expired (timeout_expired)
  );

  // State register; cause is only ever written on entry to HALT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  // Next-state logic.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_expired) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (!instr_valid) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else if (opcode == OPC_SYSTEM) begin
          state_d = ST_HALT;
          cause_d = (func3 == 3'd0) ? CAUSE_ECALL : CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (opcode)
          OPC_OP, OPC_OP_IMM, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_JAL:
            state_d = ST_WRITEBACK;
          OPC_LOAD, OPC_STORE:
            state_d = ST_MEM;
          OPC_BRANCH, OPC_MEM_MISC:
            state_d = ST_FETCH;
          default: begin
            // Opcode the decoder flagged legal but this FSM cannot sequence.
            state_d = ST_HALT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d = (opcode == OPC_STORE) ? ST_FETCH : ST_WRITEBACK;
        end else if (timeout_expired) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_HALT:      state_d = ST_HALT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Output logic: Moore-style except for the mem_ready / branch_taken
  // qualified strobes (ir_load, store completion, branch target).
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PC_SRC_PLUS4;
    alu_a_sel    = ALU_A_RS1;
    alu_b_sel    = ALU_B_RS2;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    retire       = 1'b0;
    halted       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        ir_load = mem_ready;
      end
      ST_EXECUTE: begin
        alu_a_sel = alu_sel.a_sel;
        alu_b_sel = alu_sel.b_sel;
        if (opcode == OPC_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
          retire   = 1'b1;
        end else if (opcode == OPC_MEM_MISC) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_MEM: begin
        // ALU keeps producing the address for the whole access.
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OPC_STORE);
        alu_a_sel    = alu_sel.a_sel;
        alu_b_sel    = alu_sel.b_sel;
        if (mem_ready && (opcode == OPC_STORE)) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      ST_WRITEBACK: begin
        // There is no ALU output register, so operands stay selected while
        // the result is written back (and used as the JALR target).
        alu_a_sel = alu_sel.a_sel;
        alu_b_sel = alu_sel.b_sel;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        case (opcode)
          OPC_LOAD: wb_sel = WB_LOAD;
          OPC_JAL: begin
            wb_sel = WB_PC4;
            pc_src = PC_SRC_IMM;
          end
          OPC_JALR: begin
            wb_sel = WB_PC4;
            pc_src = PC_SRC_ALU;
          end
          default: ;
        endcase
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  // Retired-instruction counter, wraps modulo 2^CNT_WIDTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  assign instret = instret_q;
  assign cause   = cause_q;
  assign state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Self-checking bench for control_unit. Each test task builds the expected
//   per-cycle control vector from the instruction class, drives the matching
//   decoder/memory inputs, and compares observed against expected vectors.
//   Small parameters (CNT_WIDTH = 4, MEM_TIMEOUT = 4) expose counter wrap and
//   the bus timeout within a short run.
// -----------------------------------------------------------------------------
module tb_control_unit;

  localparam int CNT_WIDTH   = 4;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [31:0] I_ADDI  = 32'h00500093;
  localparam logic [31:0] I_LW    = 32'h0000A103;
  localparam logic [31:0] I_SW    = 32'h0020A023;
  localparam logic [31:0] I_BEQ   = 32'h00208463;
  localparam logic [31:0] I_FENCE = 32'h0000000F;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_CSRRW = 32'h00001073;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_AUIPC = 32'h00001097;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_JALR  = 32'h000080E7;

  logic                 clk;
  logic                 reset_n;
  logic [6:0]           opcode;
  logic [2:0]           func3;
  logic                 instr_valid;
  logic                 branch_taken;
  logic                 mem_ready;
  logic                 mem_req;
  logic                 mem_we;
  logic                 mem_addr_sel;
  logic                 ir_load;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic [1:0]           alu_a_sel;
  logic                 alu_b_sel;
  logic                 reg_write;
  logic [1:0]           wb_sel;
  logic                 retire;
  logic [CNT_WIDTH-1:0] instret;
  logic                 halted;
  logic [1:0]           cause;
  logic [2:0]           state;

  control_unit #(
    .CNT_WIDTH   (CNT_WIDTH),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .opcode       (opcode),
    .func3        (func3),
    .instr_valid  (instr_valid),
    .branch_taken (branch_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .alu_a_sel    (alu_a_sel),
    .alu_b_sel    (alu_b_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .instret      (instret),
    .halted       (halted),
    .cause        (cause),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic                 mem_req;
    logic                 mem_we;
    logic                 mem_addr_sel;
    logic                 ir_load;
    logic                 pc_write;
    logic [1:0]           pc_src;
    logic [1:0]           alu_a_sel;
    logic                 alu_b_sel;
    logic                 reg_write;
    logic [1:0]           wb_sel;
    logic                 retire;
    logic                 halted;
    logic [1:0]           cause;
    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] instret;
  } ctl_t;

  ctl_t  exp_q[$];
  ctl_t  obs_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  logic [CNT_WIDTH-1:0] exp_instret;
  logic [1:0]           exp_cause;

  function automatic ctl_t sample();
    ctl_t r;
    r.mem_req      = mem_req;
    r.mem_we       = mem_we;
    r.mem_addr_sel = mem_addr_sel;
    r.ir_load      = ir_load;
    r.pc_write     = pc_write;
    r.pc_src       = pc_src;
    r.alu_a_sel    = alu_a_sel;
    r.alu_b_sel    = alu_b_sel;
    r.reg_write    = reg_write;
    r.wb_sel       = wb_sel;
    r.retire       = retire;
    r.halted       = halted;
    r.cause        = cause;
    r.state        = state;
    r.instret      = instret;
    return r;
  endfunction

  function automatic string fmt(input ctl_t c);
    return $sformatf("st=%0d req=%b we=%b as=%b ir=%b pw=%b ps=%0d a=%0d b=%b rw=%b wb=%0d ret=%b h=%b c=%0d n=%0d",
                     c.state, c.mem_req, c.mem_we, c.mem_addr_sel, c.ir_load, c.pc_write, c.pc_src,
                     c.alu_a_sel, c.alu_b_sel, c.reg_write, c.wb_sel, c.retire, c.halted, c.cause, c.instret);
  endfunction

  function automatic ctl_t v(input logic [2:0] st);
    ctl_t r = '0;
    r.state  = st;
    r.halted = (st == S_HALT);
    return r;
  endfunction

  // One cycle: drive inputs after the falling edge, sample 1 ns later,
  // queue expected and observed vectors, advance to the next falling edge.
  task automatic step(input string tag, input logic [31:0] instr, input logic valid,
                      input logic taken, input logic ready, input ctl_t e);
    opcode       = instr[6:0];
    func3        = instr[14:12];
    instr_valid  = valid;
    branch_taken = taken;
    mem_ready    = ready;
    e.instret    = exp_instret;
    e.cause      = exp_cause;
    #1;
    exp_q.push_back(e);
    obs_q.push_back(sample());
    tag_q.push_back(tag);
    if (e.retire) exp_instret = exp_instret + 1'b1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    opcode = '0; func3 = '0; instr_valid = 1'b0; branch_taken = 1'b0; mem_ready = 1'b0;
    exp_instret = '0;
    exp_cause   = 2'd0;
    @(negedge clk);
    reset_n = 1'b1;
    step("idle", 32'h0, 1'b0, 1'b0, 1'b0, v(S_IDLE));
  endtask

  task automatic fetch(input string tag, input int waits);
    ctl_t e = v(S_FETCH);
    e.mem_req = 1'b1;
    for (int i = 0; i < waits; i++) step(tag, 32'h0, 1'b0, 1'b0, 1'b0, e);
    e.ir_load = 1'b1;
    step(tag, 32'h0, 1'b0, 1'b0, 1'b1, e);
  endtask

  // FETCH, DECODE, EXECUTE, WRITEBACK for register-writing non-memory ops.
  task automatic wb_instr(input string tag, input logic [31:0] instr, input logic [1:0] a,
                          input logic b, input logic [1:0] wb, input logic [1:0] pcs);
    ctl_t e;
    fetch(tag, 0);
    step(tag, instr, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    e = v(S_EXEC);
    e.alu_a_sel = a; e.alu_b_sel = b;
    step(tag, instr, 1'b1, 1'b0, 1'b0, e);
    e = v(S_WB);
    e.alu_a_sel = a; e.alu_b_sel = b;
    e.reg_write = 1'b1; e.pc_write = 1'b1; e.wb_sel = wb; e.pc_src = pcs; e.retire = 1'b1;
    step(tag, instr, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic wait_fetch(input string tag);
    ctl_t e = v(S_FETCH);
    e.mem_req = 1'b1;
    step(tag, 32'h0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic test_reset();
    ctl_t ex = v(S_IDLE);
    ctl_t ob;
    ctl_t e;
    reset_n = 1'b0;
    opcode = 7'h13; func3 = 3'd0; instr_valid = 1'b1; branch_taken = 1'b1; mem_ready = 1'b1;
    exp_instret = '0; exp_cause = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      ob = sample();
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %s, expected %s", i, fmt(ob), fmt(ex));
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    step("reset_idle", 32'h0, 1'b0, 1'b0, 1'b1, v(S_IDLE));
    e = v(S_FETCH); e.mem_req = 1'b1;
    step("reset_fetch", 32'h0, 1'b0, 1'b0, 1'b0, e);
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_addi();
    apply_reset();
    wb_instr("addi", I_ADDI, 2'd0, 1'b1, 2'd0, 2'd0);
    wait_fetch("addi_next");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_load();
    ctl_t e;
    apply_reset();
    fetch("lw_fetch", 0);
    step("lw_decode", I_LW, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    e = v(S_EXEC); e.alu_b_sel = 1'b1;
    step("lw_exec", I_LW, 1'b1, 1'b0, 1'b0, e);
    e = v(S_MEM); e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.alu_b_sel = 1'b1;
    for (int i = 0; i < 3; i++) step("lw_mem_wait", I_LW, 1'b1, 1'b0, 1'b0, e);
    step("lw_mem_ready", I_LW, 1'b1, 1'b0, 1'b1, e);
    e = v(S_WB); e.alu_b_sel = 1'b1; e.reg_write = 1'b1; e.pc_write = 1'b1;
    e.wb_sel = 2'd1; e.retire = 1'b1;
    step("lw_wb", I_LW, 1'b1, 1'b0, 1'b0, e);
    wait_fetch("lw_next");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_branch();
    ctl_t e;
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      logic taken = (k == 0);
      fetch("beq_fetch", 0);
      step("beq_decode", I_BEQ, 1'b1, ~taken, 1'b0, v(S_DECODE));
      e = v(S_EXEC); e.pc_write = 1'b1; e.pc_src = taken ? 2'd1 : 2'd0; e.retire = 1'b1;
      step(taken ? "beq_taken" : "beq_not_taken", I_BEQ, 1'b1, taken, 1'b0, e);
    end
    wait_fetch("beq_next");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    fetch("illegal_fetch", 0);
    step("illegal_decode", 32'h0, 1'b0, 1'b0, 1'b0, v(S_DECODE));
    exp_cause = 2'd2;
    // Decoder/memory activity while halted must be ignored.
    for (int i = 0; i < 20; i++) step("illegal_halt", I_ADDI, 1'b1, 1'b1, i[0], v(S_HALT));
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_system();
    apply_reset();
    fetch("ecall_fetch", 0);
    step("ecall_decode", I_ECALL, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    exp_cause = 2'd1;
    for (int i = 0; i < 3; i++) step("ecall_halt", 32'h0, 1'b0, 1'b0, 1'b1, v(S_HALT));
    apply_reset();
    fetch("csr_fetch", 0);
    step("csr_decode", I_CSRRW, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    exp_cause = 2'd2;
    for (int i = 0; i < 3; i++) step("csr_halt", 32'h0, 1'b0, 1'b0, 1'b0, v(S_HALT));
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    for (int i = 0; i < MEM_TIMEOUT; i++) wait_fetch("timeout_wait");
    exp_cause = 2'd3;
    for (int i = 0; i < 4; i++) step("timeout_halt", 32'h0, 1'b0, 1'b0, i[1], v(S_HALT));
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_back_to_back();
    ctl_t e;
    apply_reset();
    wb_instr("add",   I_ADD,   2'd0, 1'b0, 2'd0, 2'd0);
    wb_instr("lui",   I_LUI,   2'd2, 1'b1, 2'd0, 2'd0);
    wb_instr("auipc", I_AUIPC, 2'd1, 1'b1, 2'd0, 2'd0);
    wb_instr("jal",   I_JAL,   2'd0, 1'b0, 2'd2, 2'd1);
    wb_instr("jalr",  I_JALR,  2'd0, 1'b1, 2'd2, 2'd2);
    // Store with one bus-wait cycle short of the timeout in FETCH.
    fetch("sw_fetch", MEM_TIMEOUT - 1);
    step("sw_decode", I_SW, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    e = v(S_EXEC); e.alu_b_sel = 1'b1;
    step("sw_exec", I_SW, 1'b1, 1'b0, 1'b0, e);
    e = v(S_MEM); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1; e.alu_b_sel = 1'b1;
    e.pc_write = 1'b1; e.retire = 1'b1;
    step("sw_mem", I_SW, 1'b1, 1'b0, 1'b1, e);
    wait_fetch("b2b_next");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_wrap();
    ctl_t e;
    apply_reset();
    for (int i = 0; i < (1 << CNT_WIDTH) + 1; i++) begin
      fetch("fence_fetch", 0);
      step("fence_decode", I_FENCE, 1'b1, 1'b0, 1'b0, v(S_DECODE));
      e = v(S_EXEC); e.pc_write = 1'b1; e.retire = 1'b1;
      step("fence_exec", I_FENCE, 1'b1, 1'b0, 1'b0, e);
    end
    wait_fetch("wrap_next");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  task automatic test_reset_mid_mem();
    ctl_t e;
    apply_reset();
    wb_instr("pre_addi", I_ADDI, 2'd0, 1'b1, 2'd0, 2'd0);
    fetch("sw2_fetch", 0);
    step("sw2_decode", I_SW, 1'b1, 1'b0, 1'b0, v(S_DECODE));
    e = v(S_EXEC); e.alu_b_sel = 1'b1;
    step("sw2_exec", I_SW, 1'b1, 1'b0, 1'b0, e);
    e = v(S_MEM); e.mem_req = 1'b1; e.mem_we = 1'b1; e.mem_addr_sel = 1'b1; e.alu_b_sel = 1'b1;
    step("sw2_mem_wait", I_SW, 1'b1, 1'b0, 1'b0, e);
    // Still in MEM with the request pending; assert reset between clock edges.
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_mem_req: got %b, expected 1", mem_req); end
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin errors++; $display("FAIL async_reset_mem_req: got %b, expected 0", mem_req); end
    checks++;
    if (state !== S_IDLE) begin errors++; $display("FAIL async_reset_state: got %0d, expected %0d", state, S_IDLE); end
    checks++;
    if (instret !== '0) begin errors++; $display("FAIL async_reset_instret: got %0d, expected 0", instret); end
    @(negedge clk);
    reset_n = 1'b1;
    exp_instret = '0;
    step("post_reset_idle", 32'h0, 1'b0, 1'b0, 1'b0, v(S_IDLE));
    wait_fetch("post_reset_fetch");
    while (exp_q.size() > 0) begin
      ctl_t  x = exp_q.pop_front();
      ctl_t  o = obs_q.pop_front();
      string t = tag_q.pop_front();
      checks++;
      if (o !== x) begin errors++; $display("FAIL %s: got %s, expected %s", t, fmt(o), fmt(x)); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_addi();
    test_load();
    test_branch();
    test_illegal();
    test_system();
    test_timeout();
    test_back_to_back();
    test_wrap();
    test_reset_mid_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
